// File: rtl/sample_pkg.sv
// -----------------------------------------------------------------------------
// sample_pkg
//   Shared types and constants for the audio sample path.
//   sample_t     : stereo sample, left (lc) and right (rc) channel words, each
//                  SAMPLE_WIDTH bits, two's complement.
//   I2S_*        : default framing of the DAC I2S link.
//   tx_state_e   : start-up state of the I2S transmitter.
// -----------------------------------------------------------------------------
package sample_pkg;

  localparam int unsigned SAMPLE_WIDTH = 24;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] lc;
    logic [SAMPLE_WIDTH-1:0] rc;
  } sample_t;

  localparam int unsigned I2S_SLOT_WIDTH = 32;
  localparam int unsigned I2S_BCLK_DIV   = 4;

  // TX_START: out of reset, no frame on the wire yet; the first fall strobe
  //           loads a frame without advancing the position counter.
  // TX_RUN  : free-running framing.
  typedef enum logic {
    TX_START = 1'b0,
    TX_RUN   = 1'b1
  } tx_state_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// -----------------------------------------------------------------------------
// i2s_clk_gen
//   Divides the system clock down to the I2S bit clock and produces one-cycle
//   strobes marking the clk edge on which sclk rises or falls.
//   Ports:
//     clk      in  : system clock
//     rst      in  : asynchronous active-low reset
//     sclk     out : bit clock, period 2*BCLK_DIV clk cycles, 0 in reset
//     rise_stb out : high in the clk cycle whose closing edge drives sclk 0->1
//     fall_stb out : high in the clk cycle whose closing edge drives sclk 1->0
// -----------------------------------------------------------------------------
module i2s_clk_gen
  import sample_pkg::*;
#(
  parameter int unsigned BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned     DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             wrap;

  always_comb begin
    wrap   = (div_q == DIV_LAST);
    div_d  = wrap ? '0 : div_q + DIV_W'(1);
    sclk_d = wrap ? ~sclk_q : sclk_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  // Strobes are combinational so that logic acting on them updates on the
  // same clk edge that moves sclk.
  assign sclk     = sclk_q;
  assign rise_stb = wrap & ~sclk_q;
  assign fall_stb = wrap &  sclk_q;

endmodule

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
//   Philips I2S transmitter for the DAC. Accepts one stereo sample per valid
//   pulse into a single pending register and serialises one frame per
//   2*SLOT_WIDTH bit clocks, MSB first, with the standard one-bclk data delay
//   after word-select. If no new sample is pending at a frame boundary the
//   previous sample is repeated.
//   Ports:
//     clk     in  : system clock
//     rst     in  : asynchronous active-low reset
//     data_i  in  : stereo sample (sample_t)
//     vld_i   in  : one-cycle pulse qualifying data_i
//     sclk    out : I2S bit clock
//     lrclk   out : word select, 0 = left slot, 1 = right slot
//     sdata   out : serial data, changes only when sclk falls
//     frame_o out : one-cycle pulse after a frame is loaded into the shifter
//     ovf_o   out : sticky, a pending sample was overwritten unsent
//     udf_o   out : sticky, a frame started with no new pending sample
// -----------------------------------------------------------------------------
module i2s_tx
  import sample_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
  parameter int unsigned SLOT_WIDTH = I2S_SLOT_WIDTH,
  parameter int unsigned BCLK_DIV   = I2S_BCLK_DIV
) (
  input  logic    clk,
  input  logic    rst,
  input  sample_t data_i,
  input  logic    vld_i,
  output logic    sclk,
  output logic    lrclk,
  output logic    sdata,
  output logic    frame_o,
  output logic    ovf_o,
  output logic    udf_o
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned POS_W      = $clog2(FRAME_BITS);
  localparam int unsigned PAD_W      = SLOT_WIDTH - DATA_WIDTH;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0] POS_HALF = POS_W'(SLOT_WIDTH);

  // Frame image with frame bit 0 (left MSB) in the top bit, so the shifter
  // only ever moves towards the MSB.
  function automatic logic [FRAME_BITS-1:0] frame_bits(input sample_t s);
    return {s.lc, PAD_W'(0), s.rc, PAD_W'(0)};
  endfunction

  logic rise_stb;
  logic fall_stb;

  i2s_clk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  tx_state_e             state_q, state_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  sample_t               pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  sample_t               last_q, last_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  frame_q, frame_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  load;
  logic                  consume;
  sample_t               src;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TX_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    sh_d       = sh_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    last_d     = last_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    frame_d    = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

    // The first fall after reset enters pos 0 directly, so a frame goes out
    // straight away instead of after one idle frame.
    load    = fall_stb && ((state_q == TX_START) || (pos_q == POS_LAST));
    consume = load && pend_vld_q;
    src     = pend_vld_q ? pend_q : last_q;

    if (fall_stb) begin
      state_d = TX_RUN;
      pos_d   = load ? '0 : pos_q + POS_W'(1);
      lrclk_d = (pos_d >= POS_HALF);
      // One-bclk I2S delay: the bit leaving the shifter now is the one that
      // was at the head during the previous position.
      sdata_d = sh_q[FRAME_BITS-1];
      sh_d    = load ? frame_bits(src) : {sh_q[FRAME_BITS-2:0], 1'b0};
    end

    if (load) begin
      last_d  = src;
      frame_d = 1'b1;
      if (!pend_vld_q) begin
        udf_d = 1'b1;
      end
    end

    // A sample arriving on the load edge lands behind the one being consumed.
    if (consume) begin
      pend_vld_d = 1'b0;
    end
    if (vld_i) begin
      pend_d     = data_i;
      pend_vld_d = 1'b1;
      if (pend_vld_q && !consume) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q      <= '0;
      sh_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      last_q     <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      frame_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      sh_q       <= sh_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      last_q     <= last_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      frame_q    <= frame_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign lrclk   = lrclk_q;
  assign sdata   = sdata_q;
  assign frame_o = frame_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

  a_strobes_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(rise_stb && fall_stb));

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx
//   Scoreboard bench for i2s_tx with default parameters (24/32/4).
//   The driver applies stimulus and, from the frame-timing rules alone,
//   predicts which sample every frame must carry, pushing it into exp_q.
//   An independent decoder acts as the DAC: it samples lrclk/sdata on rising
//   sclk, rebuilds each stereo frame and pops/compares against exp_q.
//   Clock, word-select, frame pulse and sticky flags are also checked every
//   clk cycle against timing derived from edge counts.
// -----------------------------------------------------------------------------
module tb_i2s_tx;
  import sample_pkg::*;

  localparam int FRAME_CLK  = 512;  // 2*BCLK_DIV*2*SLOT_WIDTH
  localparam int FIRST_LOAD = 8;    // first fall strobe after reset release

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  sample_t data_i;
  logic    vld_i;
  logic    sclk, lrclk, sdata, frame_o, ovf_o, udf_o;

  always #5 clk = ~clk;

  i2s_tx #(
    .DATA_WIDTH (SAMPLE_WIDTH),
    .SLOT_WIDTH (32),
    .BCLK_DIV   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .vld_i   (vld_i),
    .sclk    (sclk),
    .lrclk   (lrclk),
    .sdata   (sdata),
    .frame_o (frame_o),
    .ovf_o   (ovf_o),
    .udf_o   (udf_o)
  );

  int      n_cmp  = 0;
  int      n_err  = 0;
  int      edge_n = 0;   // clk rising edges since reset release
  int      epoch  = 0;   // bumped on every reset so the decoder restarts
  sample_t exp_q[$];

  // Reference model state: one pending slot, last sent sample, sticky flags.
  sample_t m_pend, m_last;
  bit      m_pv, m_ovf, m_udf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic sample_t mk(input logic [23:0] l, input logic [23:0] r);
    sample_t s;
    s.lc = l;
    s.rc = r;
    return s;
  endfunction

  function automatic bit is_load(input int n);
    return (n >= FIRST_LOAD) && (((n - FIRST_LOAD) % FRAME_CLK) == 0);
  endfunction

  task automatic model_clear();
    m_pend = '0;
    m_last = '0;
    m_pv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    exp_q.delete();
  endtask

  // Effect of clk edge n, with vld/data as presented before that edge.
  task automatic model_edge(input int n, input bit v, input sample_t d);
    if (is_load(n)) begin
      if (m_pv) begin
        m_last = m_pend;
        m_pv   = 1'b0;
      end else begin
        m_udf = 1'b1;
      end
      exp_q.push_back(m_last);
    end
    if (v) begin
      if (m_pv) m_ovf = 1'b1;
      m_pend = d;
      m_pv   = 1'b1;
    end
  endtask

  task automatic check_cycle();
    int n;
    bit e_sclk, e_lr;
    n      = edge_n;
    e_sclk = ((n / 4) % 2) == 1;
    e_lr   = (n >= FIRST_LOAD) && ((((n - FIRST_LOAD) / 8) % 64) >= 32);
    chk("sclk",    64'(sclk),    64'(e_sclk));
    chk("lrclk",   64'(lrclk),   64'(e_lr));
    chk("frame_o", 64'(frame_o), 64'(is_load(n)));
    chk("ovf_o",   64'(ovf_o),   64'(m_ovf));
    chk("udf_o",   64'(udf_o),   64'(m_udf));
  endtask

  task automatic step(input bit v, input sample_t d);
    vld_i  = v;
    data_i = d;
    model_edge(edge_n + 1, v, d);
    @(posedge clk);
    edge_n++;
    #1;
    vld_i  = 1'b0;
    check_cycle();
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) step(1'b0, '0);
  endtask

  task automatic pulse_at(input int target, input sample_t d);
    while (edge_n + 1 < target) step(1'b0, '0);
    step(1'b1, d);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_sclk"},  64'(sclk),    64'(0));
    chk({tag, "_lrclk"}, 64'(lrclk),   64'(0));
    chk({tag, "_sdata"}, 64'(sdata),   64'(0));
    chk({tag, "_frame"}, 64'(frame_o), 64'(0));
    chk({tag, "_ovf"},   64'(ovf_o),   64'(0));
    chk({tag, "_udf"},   64'(udf_o),   64'(0));
  endtask

  // Called 1 time unit after a clk edge; asserts reset between edges.
  task automatic reset_now();
    vld_i  = 1'b0;
    data_i = '0;
    #2 rst = 1'b0;
    #1 chk_outputs_zero("rst_async");
    model_clear();
    epoch++;
    repeat (2) @(posedge clk);
    #1 chk_outputs_zero("rst_hold");
    rst    = 1'b1;
    edge_n = 0;
  endtask

  // DAC-side decoder and scoreboard monitor.
  initial begin
    int          ep;
    bit          plr, have_l;
    logic [31:0] sr, lw;
    sample_t     e;
    ep = epoch; plr = 1'b0; have_l = 1'b0; sr = '0; lw = '0;
    forever begin
      @(posedge sclk);
      #1;
      if (ep != epoch) begin
        ep = epoch; plr = 1'b0; have_l = 1'b0; sr = '0;
      end
      sr = {sr[30:0], sdata};
      if (!plr && lrclk) begin
        lw     = sr;          // frame bits 0..31, bit 0 oldest
        have_l = 1'b1;
      end else if (plr && !lrclk && have_l) begin
        chk("frame_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("left_word",  64'(lw[31:8]), 64'(e.lc));
          chk("right_word", 64'(sr[31:8]), 64'(e.rc));
          chk("left_pad",   64'(lw[7:0]),  64'(0));
          chk("right_pad",  64'(sr[7:0]),  64'(0));
        end
        have_l = 1'b0;
      end
      plr = lrclk;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] base;
    int          k;
    vld_i  = 1'b0;
    data_i = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 chk_outputs_zero("rst_init");
    rst    = 1'b1;
    edge_n = 0;

    // Single sample, then repeated frames with underflow from the 2nd load.
    pulse_at(3, mk(24'hA5A5A5, 24'h800001));
    run_to(FIRST_LOAD + 3 * FRAME_CLK + 300);

    // Mid-frame reset, then a second underflow sequence.
    reset_now();
    pulse_at(1, mk(24'h123456, 24'h654321));
    run_to(1600);

    // Sample on the exact load edge while another one is pending.
    pulse_at(1700, mk(24'h0ABCDE, 24'h0FEDCB));
    pulse_at(FIRST_LOAD + 4 * FRAME_CLK, mk(24'h111111, 24'h222222));

    // Two samples 10 clk apart inside one frame: second wins, ovf sets.
    run_to(2600);
    pulse_at(2601, mk(24'h000001, 24'h000001));
    pulse_at(2611, mk(24'h000002, 24'h000002));
    run_to(3300);

    // Streaming ramp, one sample per frame at a random point in the frame.
    reset_now();
    base = 24'($urandom);
    pulse_at(2, mk(base, ~base));
    for (int i = 1; i < 100; i++) begin
      pulse_at(FIRST_LOAD + (i - 1) * FRAME_CLK + $urandom_range(1, 511),
               mk(24'(base + 24'(i)), 24'($urandom)));
    end

    // Random traffic, including overruns and gaps.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, mk(24'($urandom), 24'($urandom)));
    end

    // Stop just after a frame has been decoded: only the frame on the wire
    // may remain expected.
    k = (edge_n - FIRST_LOAD) / FRAME_CLK + 1;
    run_to(FIRST_LOAD + k * FRAME_CLK + 8);
    chk("drain", 64'(exp_q.size()), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Output stage directly downstream of the effects pipeline.
- Consumes the processed stereo sample stream (sample_t plus a one-cycle valid pulse) and serialises it onto a standard Philips I2S link to the DAC.
- Generates its own bit clock and word-select from the system clock.
- Holds one pending sample so the sample-rate producer and the fixed-rate frame clock can free-run against each other; overflow and underflow are flagged.

Parameters:
- DATA_WIDTH, 24: bits per channel sample, which is $bits(sample_t.lc).
- SLOT_WIDTH, 32: bclk periods per channel slot. Must satisfy SLOT_WIDTH >= DATA_WIDTH+1.
- BCLK_DIV, 4: clk cycles per bclk half-period, minimum 2. Frame length = 2*BCLK_DIV*2*SLOT_WIDTH clk cycles.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- data_i, input, sample_t: stereo sample (lc, rc), each DATA_WIDTH bits, two's complement.
- vld_i, input, 1: one-cycle pulse qualifying data_i.
- sclk, output, 1: I2S bit clock.
- lrclk, output, 1: word select. 0 = left slot, 1 = right slot.
- sdata, output, 1: serial data, MSB first.
- frame_o, output, 1: one-cycle pulse when a new frame is loaded into the shifter.
- ovf_o, output, 1: sticky; a pending sample was overwritten before transmission.
- udf_o, output, 1: sticky; a frame started with no new pending sample.

Behaviour:
- Reset (rst=0, asynchronous): all state and outputs clear.
  - sclk=0, lrclk=0, sdata=0, frame_o=0, ovf_o=0, udf_o=0.
  - Pending register empty; shifter and last-sample register zero; counters zero.
- Clock divider:
  - div_cnt counts 0..BCLK_DIV-1. At wrap, sclk toggles.
  - Toggle 0->1 asserts an internal rise strobe; toggle 1->0 asserts a fall strobe.
  - First fall strobe occurs 2*BCLK_DIV cycles after reset release.
- Frame position pos counts 0..2*SLOT_WIDTH-1 and advances on each fall strobe, wrapping to 0. All output changes happen only on fall strobes, so the DAC samples on rising sclk.
- lrclk after the fall strobe that enters pos is (pos >= SLOT_WIDTH).
- sdata has a one-bclk delay (I2S):
  - Bit presented during pos p is frame bit p-1 (frame bit 2*SLOT_WIDTH-1 of the previous frame when p=0).
  - Frame bit q with slot-local index k = q mod SLOT_WIDTH is channel[DATA_WIDTH-1-k] when k < DATA_WIDTH, else 0.
  - Channel is lc for q < SLOT_WIDTH, rc otherwise.
- Frame load happens on the fall strobe entering pos=0:
  - The shifter takes the pending sample if pending is valid, and pending clears.
  - Otherwise the shifter takes the last transmitted sample and udf_o sets.
  - frame_o pulses in the cycle after that strobe.
- Input capture:
  - vld_i=1 writes data_i into pending and sets pending valid.
  - If pending was already valid and is not being consumed in the same cycle, the data is overwritten and ovf_o sets.
  - Simultaneous vld_i and frame load: the old pending value goes to the shifter and the new sample becomes pending. No ovf.
- Sticky flags clear only on reset.
- Latency:
  - Sample accepted at most 1 frame before its frame load.
  - Left MSB appears on sdata one bclk after lrclk falls.
- Reset asserted mid-frame: outputs drop to reset values immediately and the frame is abandoned. After release, operation restarts at pos=0 with a zero/last-sample frame (udf_o sets on the first frame if no vld_i).

Decomposition:
- Add to sample_pkg:
  - localparam I2S_SLOT_WIDTH = 32.
  - localparam I2S_BCLK_DIV = 4.
  - sample_t is reused unchanged.
- One sub-module: i2s_clk_gen (parameter BCLK_DIV; ports clk, rst, sclk, rise_stb, fall_stb). It holds the divider and strobe generation.
- The pending register, position counter and shifter stay in i2s_tx.

Test Plan:
- Reset values, then idle:
  - Hold rst=0 mid-frame → all outputs 0 within the same cycle.
  - Release → first sclk rise after 4 clk, sclk period 8 clk, lrclk period 512 clk.
- Single sample:
  - One vld_i with lc=24'hA5A5A5, rc=24'h800001, then one frame captured on sclk rise.
  - Left slot bits 1..24 = A5A5A5; right slot bits 33..56 = 800001; all other bits 0; frame_o pulses once.
- Underflow:
  - No vld_i for 3 frames after one sample 24'h123456/24'h654321.
  - Same sample retransmitted every frame; udf_o=1 from the second load.
- Overflow:
  - Two vld_i pulses 10 clk apart within one frame (values 1 then 2) → frame carries 2; ovf_o=1.
- Simultaneous:
  - vld_i asserted in the exact cycle of the pos=0 load strobe with a different pending value.
  - Old value is sent, new value is sent next frame, ovf_o stays 0.
- Streaming:
  - vld_i once per frame for 100 frames with an incrementing ramp.
  - Decoded DAC stream equals the input sequence; ovf_o=udf_o=0.
